// File: rtl/fifo_symbol_reader.sv
// Pops serial bits from a 1-bit FIFO, packs BITS_PER_SYM of them MSB-first and offers
// the symbol over valid/ready. Define SYM_READER_GRAY_EN to Gray-encode symData.
module fifo_symbol_reader #(
   parameter int BITS_PER_SYM = 2,
   parameter int RD_LATENCY   = 1
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    fBEmpty,
   input  logic                    fDOut,
   output logic                    fREn,
   output logic [BITS_PER_SYM-1:0] symData,
   output logic                    symValid,
   input  logic                    symReady,
   output logic                    busy
);

   localparam int CW = $clog2(BITS_PER_SYM + 1);
   localparam int LW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BITS_PER_SYM - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(RD_LATENCY - 1);

   typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

   state_t                  state_q;
   logic [CW-1:0]           bit_cnt_q;
   logic [LW-1:0]           lat_cnt_q;
   logic [BITS_PER_SYM-1:0] shift_q;
   logic [BITS_PER_SYM-1:0] sym_q;
   logic                    valid_q;
   logic                    busy_q;
   logic [BITS_PER_SYM-1:0] bin_d;
   logic [BITS_PER_SYM-1:0] sym_d;

   // Packed symbol as it will look once the bit arriving now is shifted in.
   always_comb begin
      bin_d    = shift_q << 1;
      bin_d[0] = fDOut;
   end

`ifdef SYM_READER_GRAY_EN
   assign sym_d = bin_d ^ (bin_d >> 1);
`else
   assign sym_d = bin_d;
`endif

   assign fREn     = (state_q == FETCH) && !fBEmpty && !RST;
   assign symData  = sym_q;
   assign symValid = valid_q;
   assign busy     = busy_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= FETCH;
         bit_cnt_q <= '0;
         lat_cnt_q <= '0;
         shift_q   <= '0;
         sym_q     <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            FETCH: begin
               if (!fBEmpty) begin
                  state_q   <= WAIT;
                  lat_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            WAIT: begin
               if (lat_cnt_q == LAT_LAST) begin
                  shift_q   <= bin_d;
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == CNT_LAST) begin
                     sym_q   <= sym_d;
                     valid_q <= 1'b1;
                     state_q <= HOLD;
                  end else begin
                     state_q <= FETCH;
                  end
               end else begin
                  lat_cnt_q <= lat_cnt_q + 1'b1;
               end
            end
            HOLD: begin
               // No skid buffer: reads resume only after the symbol is taken.
               if (symReady) begin
                  valid_q   <= 1'b0;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_symbol_reader.sv
// Bench for fifo_symbol_reader: one 2-bit/lat-1 and one 3-bit/lat-2 instance, each fed
// by a FIFO model that predicts the symbols it will see into a scoreboard queue.
module tb_fifo_symbol_reader;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [1:0] rst, bempty, dout, ren, valid, ready, busy;
   logic [1:0] d0;
   logic [2:0] d1;
   logic [7:0] obs [2];

   always_comb begin
      obs[0] = {6'b0, d0};
      obs[1] = {5'b0, d1};
   end

   fifo_symbol_reader #(.BITS_PER_SYM(2), .RD_LATENCY(1)) u0 (
      .CLK(CLK), .RST(rst[0]), .fBEmpty(bempty[0]), .fDOut(dout[0]), .fREn(ren[0]),
      .symData(d0), .symValid(valid[0]), .symReady(ready[0]), .busy(busy[0]));

   fifo_symbol_reader #(.BITS_PER_SYM(3), .RD_LATENCY(2)) u1 (
      .CLK(CLK), .RST(rst[1]), .fBEmpty(bempty[1]), .fDOut(dout[1]), .fREn(ren[1]),
      .symData(d1), .symValid(valid[1]), .symReady(ready[1]), .busy(busy[1]));

   int total = 0;
   int bad   = 0;

   task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
      total++;
      if (o !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, o, e, $time);
      end
   endtask

   function automatic int bps(int i);
      return (i == 0) ? 2 : 3;
   endfunction

   function automatic int lat(int i);
      return (i == 0) ? 1 : 2;
   endfunction

   function automatic logic [7:0] enc(logic [7:0] b);
`ifdef SYM_READER_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   // FIFO model state and scoreboard
   bit         fq   [2][$];
   logic [7:0] expq [2][$];
   logic       took [2];
   logic       fe   [2];
   logic [3:0] dv   [2];
   logic [3:0] dlb  [2];
   logic [7:0] bld  [2];
   int         bcnt [2];

   always @(posedge CLK)
      for (int i = 0; i < 2; i++) took[i] <= ren[i];

   // Read data appears RD_LATENCY edges after the edge that sampled fREn.
   initial begin
      bit b;
      dout   = 2'b00;
      bempty = 2'b11;
      for (int i = 0; i < 2; i++) begin
         dv[i] = '0; dlb[i] = '0; bld[i] = '0; bcnt[i] = 0;
      end
      forever begin
         @(negedge CLK);
         for (int i = 0; i < 2; i++) begin
            b = 1'b0;
            if (took[i]) begin
               if (fq[i].size() > 0) b = fq[i].pop_front();
               else chk("fifo_underflow", fq[i].size(), 1);
            end
            dv[i]  = {dv[i][2:0], took[i]};
            dlb[i] = {dlb[i][2:0], b};
            if (rst[i]) begin
               dv[i] = '0; bld[i] = '0; bcnt[i] = 0;
               expq[i].delete();
            end else if (dv[i][lat(i)-1]) begin
               bld[i] = {bld[i][6:0], dlb[i][lat(i)-1]};
               bcnt[i]++;
               if (bcnt[i] == bps(i)) begin
                  expq[i].push_back(enc(bld[i]));
                  bld[i]  = '0;
                  bcnt[i] = 0;
               end
            end
            dout[i]   = dlb[i][lat(i)-1];
            bempty[i] = fe[i] || (fq[i].size() == 0);
         end
      end
   end

   // Protocol monitor and scoreboard compare
   initial begin
      logic       pv [2];
      logic       pr [2];
      logic [7:0] pd [2];
      for (int i = 0; i < 2; i++) begin
         pv[i] = 1'b0; pr[i] = 1'b1; pd[i] = '0;
      end
      forever begin
         @(negedge CLK); #1;
         for (int i = 0; i < 2; i++) begin
            if (rst[i]) chk("ren_in_rst", ren[i], 0);
            if (bempty[i]) chk("ren_when_empty", ren[i], 0);
            if (!rst[i] && pv[i] && !pr[i]) begin
               chk("hold_valid", valid[i], 1);
               chk("hold_data", obs[i], pd[i]);
            end
            if (!rst[i] && valid[i] && ready[i]) begin
               if (expq[i].size() == 0) chk("sb_size", expq[i].size(), 1);
               else chk($sformatf("sym_u%0d", i), obs[i], expq[i].pop_front());
            end
            pv[i] = valid[i] && !rst[i];
            pr[i] = ready[i];
            pd[i] = obs[i];
         end
      end
   end

   task automatic tick();
      @(negedge CLK); #1;
   endtask

   task automatic drive();
      @(posedge CLK); #2;
   endtask

   task automatic wait_idle(int i, string tag);
      int n;
      logic idle;
      n = 0;
      idle = 1'b0;
      while (!idle && n < 400) begin
         tick();
         n++;
         idle = (fq[i].size() == 0) && !busy[i] && !valid[i] && (expq[i].size() == 0);
      end
      chk(tag, idle, 1);
   endtask

   initial begin
      int n;
      rst   = 2'b11;
      ready = 2'b11;
      fe[0] = 1'b0;
      fe[1] = 1'b0;

      // Empty FIFO after reset: no reads, no symbols
      repeat (2) drive();
      rst = 2'b00;
      repeat (20) begin
         tick();
         chk("t2_ren", ren[0], 0);
         chk("t2_valid", valid[0], 0);
      end

      // Reset with a non-empty FIFO
      drive();
      rst = 2'b11;
      fq[0].push_back(1'b1);
      fq[0].push_back(1'b0);
      repeat (2) begin
         tick();
         chk("t1_ren", ren[0], 0);
         chk("t1_valid", valid[0], 0);
         chk("t1_data", obs[0], 0);
         chk("t1_busy", busy[0], 0);
      end

      // First symbol latency and single-cycle valid
      drive();
      rst = 2'b00;
      n = 0;
      do begin
         tick();
         n++;
      end while (!valid[0] && n < 20);
      chk("t3_first_valid", n, 5);
      chk("t3_data", obs[0], enc(8'b10));
      tick();
      chk("t3_one_cycle", valid[0], 0);
      wait_idle(0, "t3_idle");

      // Backpressure
      drive();
      ready[0] = 1'b0;
      fq[0].push_back(1'b1);
      fq[0].push_back(1'b1);
      fq[0].push_back(1'b0);
      fq[0].push_back(1'b1);
      n = 0;
      do begin
         tick();
         n++;
      end while (!valid[0] && n < 40);
      chk("t4_seen", valid[0], 1);
      repeat (5) begin
         tick();
         chk("t4_valid", valid[0], 1);
         chk("t4_data", obs[0], enc(8'b11));
         chk("t4_ren", ren[0], 0);
      end
      drive();
      ready[0] = 1'b1;
      tick();
      tick();
      chk("t4_valid_after", valid[0], 0);
      chk("t4_ren_after", ren[0], 1);
      wait_idle(0, "t4_idle");

      // FIFO runs dry after one bit
      drive();
      fq[0].push_back(1'b0);
      repeat (8) tick();
      chk("t5_busy", busy[0], 1);
      chk("t5_ren", ren[0], 0);
      chk("t5_valid", valid[0], 0);
      drive();
      fq[0].push_back(1'b1);
      wait_idle(0, "t5_idle");

      // Reset discards a partial symbol, both configurations
      drive();
      fq[0].push_back(1'b1);
      fq[1].push_back(1'b1);
      fq[1].push_back(1'b0);
      repeat (12) tick();
      chk("t6_busy_u0", busy[0], 1);
      chk("t6_busy_u1", busy[1], 1);
      drive();
      rst = 2'b11;
      drive();
      rst = 2'b00;
      tick();
      chk("t6_clr_u0", busy[0], 0);
      chk("t6_clr_u1", busy[1], 0);
      fq[0].push_back(1'b1);
      fq[0].push_back(1'b1);
      fq[1].push_back(1'b1);
      fq[1].push_back(1'b1);
      fq[1].push_back(1'b0);
      wait_idle(0, "t6_idle_u0");
      wait_idle(1, "t6_idle_u1");

      // Random stream with random backpressure and empty gaps
      for (int k = 0; k < 30; k++) begin
         fq[0].push_back(1'($urandom_range(0, 1)));
         fq[1].push_back(1'($urandom_range(0, 1)));
      end
      n = 0;
      while ((fq[0].size() > 0 || fq[1].size() > 0) && n < 2000) begin
         drive();
         ready = 2'($urandom);
         fe[0] = ($urandom_range(0, 5) == 0);
         fe[1] = ($urandom_range(0, 5) == 0);
         n++;
      end
      chk("rand_drained", (fq[0].size() == 0 && fq[1].size() == 0), 1);
      drive();
      ready = 2'b11;
      fe[0] = 1'b0;
      fe[1] = 1'b0;
      wait_idle(0, "rand_idle_u0");
      wait_idle(1, "rand_idle_u1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
